// File: rtl/axi2dev_if_pkg.sv
// -----------------------------------------------------------------------------
// axi2dev_if_pkg
// Shared definitions for the AXI-lite to Aquila device bridge:
//   - state_e     : bridge FSM states
//   - RESP_OKAY / RESP_SLVERR : AXI-lite response codes
//   - resp_code() : response code for a finished device wait
// -----------------------------------------------------------------------------
package axi2dev_if_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEV_WR,
    WAIT_WR,
    B_RESP,
    DEV_RD,
    WAIT_RD,
    R_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A wait ends either because the device answered or because it timed out.
  function automatic logic [1:0] resp_code(input logic dev_answered);
    return dev_answered ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi2dev_if_if.sv
// -----------------------------------------------------------------------------
// axi2dev_if_if
// AXI-lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives addresses, data, valids and response readies
//   slave  modport : drives address/data readies and responses
// Parameters: ADDR_W (address width), DATA_W (data width, multiple of 8).
// -----------------------------------------------------------------------------
interface axi2dev_if_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi2dev_if_timeout.sv
// -----------------------------------------------------------------------------
// axi2dev_timeout
// Device wait watchdog, present only when AXI2DEV_TIMEOUT_EN is defined.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   count_en      : high while the bridge waits for the device
//   expired       : high in the TIMEOUT_CYCLES-th consecutive wait cycle
// The count restarts whenever count_en drops, so every access gets a fresh
// budget.
// -----------------------------------------------------------------------------
`ifdef AXI2DEV_TIMEOUT_EN
module axi2dev_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expired = count_en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!count_en) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/axi2dev_if.sv
// -----------------------------------------------------------------------------
// axi2dev_if
// AXI-lite slave that turns read/write transactions into the Aquila device
// strobe/data_ready handshake, one device access at a time, writes first.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   s_axi (slave modport)  : AXI-lite AW/W/B/AR/R channels
//   M_DEVICE_strobe_o      : one-cycle device request
//   M_DEVICE_addr_o        : zero-extended AXI address
//   M_DEVICE_rw_o          : 1 = write, 0 = read
//   M_DEVICE_byte_enable_o : wstrb for writes, all ones for reads
//   M_DEVICE_data_o        : write data
//   M_DEVICE_data_ready_i  : device done pulse (ignored in the strobe cycle)
//   M_DEVICE_data_i        : device read data
// Optional: define AXI2DEV_TIMEOUT_EN to end a device wait after
// TIMEOUT_CYCLES cycles with SLVERR (read data forced to zero).
// All outputs are registered: each one is loaded from next-state values.
// -----------------------------------------------------------------------------
module axi2dev_if
  import axi2dev_if_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int AXI_ADDR_LEN   = 8,
  parameter int AXI_DATA_LEN   = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  axi2dev_if_if.slave       s_axi,
  output logic              M_DEVICE_strobe_o,
  output logic [XLEN-1:0]   M_DEVICE_addr_o,
  output logic              M_DEVICE_rw_o,
  output logic [XLEN/8-1:0] M_DEVICE_byte_enable_o,
  output logic [XLEN-1:0]   M_DEVICE_data_o,
  input  logic              M_DEVICE_data_ready_i,
  input  logic [XLEN-1:0]   M_DEVICE_data_i
);

  localparam int BE_W = XLEN / 8;

  if (AXI_DATA_LEN > XLEN || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("axi2dev_if: AXI_DATA_LEN must not exceed XLEN and TIMEOUT_CYCLES must be positive");
  end

  state_e                    state_q, state_nx;
  logic                      aw_cap_q, w_cap_q, ar_cap_q;
  logic                      aw_cap_nx, w_cap_nx, ar_cap_nx;
  logic [AXI_ADDR_LEN-1:0]   awaddr_q, araddr_q, awaddr_nx, araddr_nx;
  logic [AXI_DATA_LEN-1:0]   wdata_q, wdata_nx;
  logic [AXI_DATA_LEN/8-1:0] wstrb_q, wstrb_nx;

  logic                      awready_q, wready_q, arready_q;
  logic                      bvalid_q, rvalid_q;
  logic [1:0]                bresp_q, rresp_q;
  logic [AXI_DATA_LEN-1:0]   rdata_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic timeout_hit;

`ifdef AXI2DEV_TIMEOUT_EN
  axi2dev_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .count_en (state_q == WAIT_WR || state_q == WAIT_RD),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.arready = arready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  // Captures include this cycle's handshakes so the FSM can leave IDLE on the
  // same edge that completes AW/W/AR, giving strobe one cycle after capture.
  always_comb begin
    // NOTE: every signal gets a value before the case; a path that skips an
    // assignment would otherwise infer a latch.
    aw_hs     = s_axi.awvalid && awready_q;
    w_hs      = s_axi.wvalid  && wready_q;
    ar_hs     = s_axi.arvalid && arready_q;
    b_hs      = bvalid_q && s_axi.bready;
    r_hs      = rvalid_q && s_axi.rready;
    aw_cap_nx = aw_cap_q || aw_hs;
    w_cap_nx  = w_cap_q  || w_hs;
    ar_cap_nx = ar_cap_q || ar_hs;
    awaddr_nx = aw_hs ? s_axi.awaddr : awaddr_q;
    araddr_nx = ar_hs ? s_axi.araddr : araddr_q;
    wdata_nx  = w_hs  ? s_axi.wdata  : wdata_q;
    wstrb_nx  = w_hs  ? s_axi.wstrb  : wstrb_q;
    state_nx  = state_q;

    unique case (state_q)
      IDLE: begin
        if (aw_cap_nx && w_cap_nx) state_nx = DEV_WR;
        else if (ar_cap_nx)        state_nx = DEV_RD;
      end
      DEV_WR:  state_nx = WAIT_WR;
      WAIT_WR: if (M_DEVICE_data_ready_i || timeout_hit) state_nx = B_RESP;
      B_RESP: begin
        if (b_hs) begin
          state_nx  = IDLE;
          aw_cap_nx = 1'b0;
          w_cap_nx  = 1'b0;
        end
      end
      DEV_RD:  state_nx = WAIT_RD;
      WAIT_RD: if (M_DEVICE_data_ready_i || timeout_hit) state_nx = R_RESP;
      R_RESP: begin
        if (r_hs) begin
          state_nx  = IDLE;
          ar_cap_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge value of the others, independent of statement order.
    if (!rst_ni) begin
      state_q  <= IDLE;
      aw_cap_q <= 1'b0;
      w_cap_q  <= 1'b0;
      ar_cap_q <= 1'b0;
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_nx;
      aw_cap_q <= aw_cap_nx;
      w_cap_q  <= w_cap_nx;
      ar_cap_q <= ar_cap_nx;
      awaddr_q <= awaddr_nx;
      araddr_q <= araddr_nx;
      wdata_q  <= wdata_nx;
      wstrb_q  <= wstrb_nx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      awready_q              <= 1'b0;
      wready_q               <= 1'b0;
      arready_q              <= 1'b0;
      bvalid_q               <= 1'b0;
      bresp_q                <= RESP_OKAY;
      rvalid_q               <= 1'b0;
      rresp_q                <= RESP_OKAY;
      rdata_q                <= '0;
      M_DEVICE_strobe_o      <= 1'b0;
      M_DEVICE_addr_o        <= '0;
      M_DEVICE_rw_o          <= 1'b0;
      M_DEVICE_byte_enable_o <= '0;
      M_DEVICE_data_o        <= '0;
    end else begin
      awready_q         <= (state_nx == IDLE) && !aw_cap_nx;
      wready_q          <= (state_nx == IDLE) && !w_cap_nx;
      arready_q         <= (state_nx == IDLE) && !ar_cap_nx;
      bvalid_q          <= (state_nx == B_RESP);
      rvalid_q          <= (state_nx == R_RESP);
      M_DEVICE_strobe_o <= (state_nx == DEV_WR) || (state_nx == DEV_RD);

      // Device request payload is loaded on entry to a strobe state and then
      // held, so it stays stable for the whole access.
      if (state_q == IDLE && state_nx == DEV_WR) begin
        M_DEVICE_addr_o        <= XLEN'(awaddr_nx);
        M_DEVICE_rw_o          <= 1'b1;
        M_DEVICE_byte_enable_o <= BE_W'(wstrb_nx);
        M_DEVICE_data_o        <= XLEN'(wdata_nx);
      end else if (state_q == IDLE && state_nx == DEV_RD) begin
        M_DEVICE_addr_o        <= XLEN'(araddr_nx);
        M_DEVICE_rw_o          <= 1'b0;
        M_DEVICE_byte_enable_o <= '1;
      end

      // Data_ready wins over a coincident timeout.
      if (state_q == WAIT_WR && state_nx == B_RESP) begin
        bresp_q <= resp_code(M_DEVICE_data_ready_i);
      end
      if (state_q == WAIT_RD && state_nx == R_RESP) begin
        rresp_q <= resp_code(M_DEVICE_data_ready_i);
        rdata_q <= M_DEVICE_data_ready_i ? M_DEVICE_data_i[AXI_DATA_LEN-1:0] : '0;
      end
    end
  end

endmodule

// File: tb/tb_axi2dev_if.sv
// -----------------------------------------------------------------------------
// tb_axi2dev_if
// Scoreboard bench for axi2dev_if: stimulus pushes expected device requests
// and B/R responses into queues; a monitor on the falling edge pops and
// compares them as the DUT presents strobes and response handshakes. A small
// device model answers each strobe after a programmable latency.
// -----------------------------------------------------------------------------
module tb_axi2dev_if;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  axi2dev_if_if #(.ADDR_W(8), .DATA_W(32)) axi ();

  logic        strobe, rw, data_ready;
  logic [31:0] addr, dout, din;
  logic [3:0]  be;

  axi2dev_if #(
    .XLEN(32), .AXI_ADDR_LEN(8), .AXI_DATA_LEN(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .s_axi                  (axi),
    .M_DEVICE_strobe_o      (strobe),
    .M_DEVICE_addr_o        (addr),
    .M_DEVICE_rw_o          (rw),
    .M_DEVICE_byte_enable_o (be),
    .M_DEVICE_data_o        (dout),
    .M_DEVICE_data_ready_i  (data_ready),
    .M_DEVICE_data_i        (din)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] data;
  } dev_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_exp_t;

  dev_exp_t   dev_q[$];
  logic [1:0] b_q[$];
  rsp_exp_t   r_q[$];

  int          tests      = 0;
  int          fails      = 0;
  int          strobe_cnt = 0;
  int          dev_lat    = 1;   // 0 = device never answers
  logic [31:0] dev_rdata  = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Device model: answers a strobe dev_lat cycles later with a one-cycle pulse.
  initial begin
    data_ready = 1'b0;
    din        = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_ni && strobe && dev_lat != 0) begin
        repeat (dev_lat) @(posedge clk_i);
        #1;
        data_ready = 1'b1;
        din        = dev_rdata;
        @(posedge clk_i); #1;
        data_ready = 1'b0;
        din        = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin : monitor
    dev_exp_t e;
    rsp_exp_t r;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (strobe) begin
          strobe_cnt++;
          if (dev_q.size() == 0) begin
            check("strobe_without_expectation", strobe, 1'b0);
          end else begin
            e = dev_q.pop_front();
            check("dev_addr", addr, e.addr);
            check("dev_rw", rw, e.rw);
            check("dev_be", be, e.be);
            if (e.rw) check("dev_wdata", dout, e.data);
          end
        end
        if (axi.bvalid && b_q.size() == 0) begin
          check("bvalid_without_expectation", axi.bvalid, 1'b0);
        end else if (axi.bvalid && axi.bready) begin
          check("bresp", axi.bresp, b_q.pop_front());
        end
        if (axi.rvalid && r_q.size() == 0) begin
          check("rvalid_without_expectation", axi.rvalid, 1'b0);
        end else if (axi.rvalid && axi.rready) begin
          r = r_q.pop_front();
          check("rdata", axi.rdata, r.data);
          check("rresp", axi.rresp, r.resp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Presents the selected channels together and drops each valid after its
  // own handshake. Entered and left at #1 after a rising edge.
  task automatic send(input bit do_aw, input bit do_w, input bit do_ar,
                      input logic [7:0] awa, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [7:0] ara);
    bit aw_p, w_p, ar_p, aw_h, w_h, ar_h;
    int n;
    aw_p = do_aw; w_p = do_w; ar_p = do_ar; n = 0;
    axi.awvalid = do_aw; axi.awaddr = awa;
    axi.wvalid  = do_w;  axi.wdata  = wd; axi.wstrb = ws;
    axi.arvalid = do_ar; axi.araddr = ara;
    while ((aw_p || w_p || ar_p) && n < 50) begin
      @(negedge clk_i);
      aw_h = aw_p && axi.awready;
      w_h  = w_p  && axi.wready;
      ar_h = ar_p && axi.arready;
      tick();
      if (aw_h) begin aw_p = 1'b0; axi.awvalid = 1'b0; end
      if (w_h)  begin w_p  = 1'b0; axi.wvalid  = 1'b0; end
      if (ar_h) begin ar_p = 1'b0; axi.arvalid = 1'b0; end
      n++;
    end
    if (aw_p || w_p || ar_p) check("handshake_timeout", {aw_p, w_p, ar_p}, 3'b000);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((dev_q.size() + b_q.size() + r_q.size()) != 0 && n < budget) begin
      tick();
      n++;
    end
    if ((dev_q.size() + b_q.size() + r_q.size()) != 0)
      check("completion_timeout", dev_q.size() + b_q.size() + r_q.size(), 0);
    repeat (2) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dev_outputs"}, {strobe, rw, be, |addr, |dout}, 0);
    check({tag, "_axi_outputs"},
          {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid,
           axi.bresp, axi.rresp, |axi.rdata}, 0);
  endtask

  initial begin : stimulus
    int n;
    int s0;
    axi.awvalid = 1'b0; axi.awaddr = '0;
    axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb = '0;
    axi.arvalid = 1'b0; axi.araddr = '0;
    axi.bready  = 1'b1; axi.rready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;
    tick();
    check("idle_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);

    // 1: AW and W in the same cycle, device answers one cycle after strobe
    dev_q.push_back('{32'h10, 1'b1, 4'hF, 32'hDEADBEEF});
    b_q.push_back(2'b00);
    send(1, 1, 0, 8'h10, 32'hDEADBEEF, 4'hF, 8'h00);
    @(negedge clk_i); check("t1_strobe_cycle1", strobe, 1'b1);
    @(negedge clk_i); check("t1_quiet_cycle2", {strobe, axi.bvalid}, 2'b00);
    @(negedge clk_i); check("t1_bvalid_cycle3", axi.bvalid, 1'b1);
    wait_done(50);

    // 2: W two cycles before AW
    dev_q.push_back('{32'h24, 1'b1, 4'h3, 32'h11223344});
    b_q.push_back(2'b00);
    send(0, 1, 0, 8'h00, 32'h11223344, 4'h3, 8'h00);
    @(negedge clk_i);
    check("t2_wready_low", axi.wready, 1'b0);
    check("t2_no_early_strobe", strobe, 1'b0);
    tick();
    send(1, 0, 0, 8'h24, 32'h0, 4'h0, 8'h00);
    wait_done(50);

    // 3: read, device latency 5, rready held low 3 cycles
    axi.rready = 1'b0;
    dev_lat    = 5;
    dev_rdata  = 32'h12345678;
    dev_q.push_back('{32'h08, 1'b0, 4'hF, 32'h0});
    r_q.push_back('{32'h12345678, 2'b00});
    send(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h08);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!axi.rvalid && n < 40);
    check("t3_rvalid_latency", n, 7);
    for (int i = 0; i < 3; i++) begin
      check("t3_rvalid_hold", axi.rvalid, 1'b1);
      check("t3_rdata_hold", axi.rdata, 32'h12345678);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1; axi.rready = 1'b1;
    @(posedge clk_i); #1; axi.rready = 1'b0;
    @(negedge clk_i); check("t3_rvalid_drop", axi.rvalid, 1'b0);
    axi.rready = 1'b1;
    dev_lat    = 1;
    wait_done(20);

    // 4: AW+W+AR together: write strobe, B, then read strobe, R
    s0        = strobe_cnt;
    dev_rdata = 32'hCAFEF00D;
    dev_q.push_back('{32'h30, 1'b1, 4'hF, 32'hA5A50001});
    dev_q.push_back('{32'h34, 1'b0, 4'hF, 32'h0});
    b_q.push_back(2'b00);
    r_q.push_back('{32'hCAFEF00D, 2'b00});
    send(1, 1, 1, 8'h30, 32'hA5A50001, 4'hF, 8'h34);
    wait_done(100);
    check("t4_two_strobes", strobe_cnt - s0, 2);

    // 5: reset while waiting for a read, then a clean write
    dev_lat = 0;
    dev_q.push_back('{32'h0C, 1'b0, 4'hF, 32'h0});
    send(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h0C);
    repeat (3) tick();
    rst_ni = 1'b0;
    #1;
    check_all_zero("t5_reset");
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    check("t5_readies_after_reset", {axi.awready, axi.wready, axi.arready}, 3'b111);
    dev_lat = 1;
    dev_q.push_back('{32'h40, 1'b1, 4'hC, 32'h0BADCAFE});
    b_q.push_back(2'b00);
    send(1, 1, 0, 8'h40, 32'h0BADCAFE, 4'hC, 8'h00);
    wait_done(50);

`ifdef AXI2DEV_TIMEOUT_EN
    // 6: device never answers: SLVERR and zero data after 16 wait cycles
    dev_lat   = 0;
    dev_rdata = 32'hFFFF_FFFF;
    dev_q.push_back('{32'h50, 1'b0, 4'hF, 32'h0});
    r_q.push_back('{32'h0, 2'b10});
    send(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h50);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!axi.rvalid && n < 60);
    check("t6_timeout_latency", n, 18);
    wait_done(20);
    dev_lat = 1;
`endif

    check("scoreboard_drained", dev_q.size() + b_q.size() + r_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
